// File: rtl/fetch_sequencer.sv
// Fetch-stage PC control sequencer: boot hold, branch redirect with flush bubbles, hazard stall, HALT/resume.
// Optional performance counters are built only when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
  parameter int ADDRESS_SIZE = 10,
  parameter int FLUSH_CYCLES = 2,
  parameter int BOOT_CYCLES  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_branch_req,
  input  logic [ADDRESS_SIZE-1:0] i_branch_target,
  input  logic                    i_hazard_stall,
  input  logic                    i_halt_instr,
  input  logic                    i_resume,
  output logic                    o_program_counter_load,
  output logic                    o_program_counter_stop,
  output logic [ADDRESS_SIZE-1:0] o_program_counter,
  output logic                    o_flush,
  output logic                    o_sys_halt,
  output logic [15:0]             o_stall_count,
  output logic [15:0]             o_flush_count
);

  localparam int BOOT_W  = $clog2(BOOT_CYCLES + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [BOOT_W-1:0]  BOOT_INIT  = BOOT_W'(BOOT_CYCLES);
  localparam logic [BOOT_W-1:0]  BOOT_ONE   = BOOT_W'(1'b1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1'b1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [BOOT_W-1:0]         boot_cnt_r, boot_cnt_nxt_s;
  logic [FLUSH_W-1:0]        flush_cnt_r, flush_cnt_nxt_s;
  logic                      sys_halt_r;
  logic                      load_s, stop_s, flush_s, branch_take_s;
  logic [ADDRESS_SIZE-1:0]   pc_s;

  // State, countdown and halt-flag registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_BOOT;
      boot_cnt_r  <= BOOT_INIT;
      flush_cnt_r <= {FLUSH_W{1'b0}};
      sys_halt_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      boot_cnt_r  <= boot_cnt_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      sys_halt_r  <= (state_nxt_s == ST_HALT);
    end
  end

  // Next-state and fetch controls; halt > branch > stall > increment in RUN
  always_comb begin
    state_nxt_s     = state_r;
    boot_cnt_nxt_s  = boot_cnt_r;
    flush_cnt_nxt_s = flush_cnt_r;
    load_s          = 1'b0;
    stop_s          = 1'b0;
    flush_s         = 1'b0;
    branch_take_s   = 1'b0;
    pc_s            = {ADDRESS_SIZE{1'b0}};
    case (state_r)
      ST_BOOT: begin
        stop_s  = 1'b1;
        flush_s = 1'b1;
        if (boot_cnt_r <= BOOT_ONE) begin
          state_nxt_s    = ST_RUN;
          boot_cnt_nxt_s = {BOOT_W{1'b0}};
        end else begin
          boot_cnt_nxt_s = boot_cnt_r - BOOT_ONE;
        end
      end
      ST_RUN: begin
        if (i_halt_instr) begin
          stop_s      = 1'b1;
          flush_s     = 1'b1;
          state_nxt_s = ST_HALT;
        end else if (i_branch_req) begin
          load_s          = 1'b1;
          pc_s            = i_branch_target;
          flush_s         = 1'b1;
          branch_take_s   = 1'b1;
          flush_cnt_nxt_s = FLUSH_INIT;
          state_nxt_s     = ST_FLUSH;
        end else if (i_hazard_stall) begin
          stop_s = 1'b1;
        end else begin
          stop_s = 1'b0;
        end
      end
      // Requests here come from squashed instructions, so only stall matters
      ST_FLUSH: begin
        flush_s = 1'b1;
        if (i_hazard_stall) begin
          stop_s = 1'b1;
        end else if (flush_cnt_r <= FLUSH_ONE) begin
          flush_cnt_nxt_s = {FLUSH_W{1'b0}};
          state_nxt_s     = ST_RUN;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - FLUSH_ONE;
        end
      end
      ST_HALT: begin
        stop_s  = 1'b1;
        flush_s = 1'b1;
        if (i_resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        stop_s      = 1'b1;
        flush_s     = 1'b1;
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  assign o_program_counter_load = load_s;
  assign o_program_counter_stop = stop_s;
  assign o_program_counter      = pc_s;
  assign o_flush                = flush_s;
  assign o_sys_halt             = sys_halt_r;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;

  // Saturating stall and redirect counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_count_r <= 16'h0000;
      flush_count_r <= 16'h0000;
    end else begin
      if (stop_s && (state_r == ST_RUN || state_r == ST_FLUSH) &&
          (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
      if (branch_take_s && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end
    end
  end

  assign o_stall_count = stall_count_r;
  assign o_flush_count = flush_count_r;
`else
  assign o_stall_count = 16'h0000;
  assign o_flush_count = 16'h0000;
`endif

endmodule
